// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF evaluator: for each challenge pair, counts synchronised
// oscillator edges over a programmable window and compares the two counts.
module ro_puf_eval #(
  parameter int NUM_RO    = 8,
  parameter int SEL_W     = 3,
  parameter int RESP_BITS = 4,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic [NUM_RO-1:0]            i_ro_in,
  input  logic                         i_start,
  input  logic [RESP_BITS*2*SEL_W-1:0] i_challenge,
  input  logic [WIN_W-1:0]             i_window,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [RESP_BITS-1:0]         o_response,
  output logic                         o_resp_valid,
  output logic [RESP_BITS-1:0]         o_tie_mask,
  output logic                         o_err,
  output logic                         o_sat,
  output logic [CNT_W-1:0]             o_last_cnt_a,
  output logic [CNT_W-1:0]             o_last_cnt_b
);

  localparam int PAIR_W = 2 * SEL_W;
  localparam int IDX_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int RO_PAD = 2 ** SEL_W;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_COUNT, S_COMPARE, S_DONE} state_t;

  // Saturating increment; MSB of the result flags an edge lost at full scale.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
    if (ev && (c == {CNT_W{1'b1}})) return {1'b1, c};
    else if (ev)                    return {1'b0, c + 1'b1};
    else                            return {1'b0, c};
  endfunction

  state_t                         r_state, w_next;
  logic [NUM_RO-1:0]              r_sync1, r_sync2, r_sync3;
  logic [RESP_BITS*2*SEL_W-1:0]   r_chal;
  logic [WIN_W-1:0]               r_win_len, r_win_cnt;
  logic [IDX_W-1:0]               r_pair;
  logic [SEL_W-1:0]               r_idx_a, r_idx_b;
  logic [CNT_W-1:0]               r_cnt_a, r_cnt_b, r_last_a, r_last_b;
  logic [RESP_BITS-1:0]           r_response, r_tie;
  logic                           r_err, r_sat, r_resp_valid;
  logic                           w_busy, w_done;
  logic [RO_PAD-1:0]              w_rise;
  logic [PAIR_W-1:0]              w_pair_bits;
  logic                           w_a_ok, w_b_ok, w_ok, w_last_pair, w_win_last;
  logic [CNT_W:0]                 w_inc_a, w_inc_b;
  logic [CNT_W-1:0]               w_eff_a, w_eff_b;

  assign w_rise      = RO_PAD'(r_sync2 & ~r_sync3);
  assign w_pair_bits = r_chal[r_pair*PAIR_W +: PAIR_W];
  assign w_a_ok      = 32'(r_idx_a) < NUM_RO;
  assign w_b_ok      = 32'(r_idx_b) < NUM_RO;
  assign w_ok        = w_a_ok & w_b_ok;
  assign w_last_pair = (r_pair == IDX_W'(RESP_BITS - 1));
  assign w_win_last  = (r_win_cnt == WIN_W'(1));
  assign w_inc_a     = sat_inc(r_cnt_a, w_a_ok & w_rise[r_idx_a]);
  assign w_inc_b     = sat_inc(r_cnt_b, w_b_ok & w_rise[r_idx_b]);
  assign w_eff_a     = w_a_ok ? r_cnt_a : '0;
  assign w_eff_b     = w_b_ok ? r_cnt_b : '0;

  // Two-flop synchroniser plus previous-value register for rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
    end else begin
      r_sync1 <= i_ro_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and status decode; dropping enable returns to idle from anywhere.
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE:    if (i_en && i_start) w_next = S_CLEAR;
      S_CLEAR: begin
        w_busy = 1'b1;
        w_next = i_en ? S_COUNT : S_IDLE;
      end
      S_COUNT: begin
        w_busy = 1'b1;
        if (!i_en)          w_next = S_IDLE;
        else if (w_win_last) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        w_busy = 1'b1;
        if (!i_en)           w_next = S_IDLE;
        else if (w_last_pair) w_next = S_DONE;
        else                  w_next = S_CLEAR;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  // Request latch, per-pair counting and result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chal       <= '0;
      r_win_len    <= '0;
      r_win_cnt    <= '0;
      r_pair       <= '0;
      r_idx_a      <= '0;
      r_idx_b      <= '0;
      r_cnt_a      <= '0;
      r_cnt_b      <= '0;
      r_last_a     <= '0;
      r_last_b     <= '0;
      r_response   <= '0;
      r_tie        <= '0;
      r_err        <= 1'b0;
      r_sat        <= 1'b0;
      r_resp_valid <= 1'b0;
    end else if (i_en) begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_chal       <= i_challenge;
          r_win_len    <= (i_window == '0) ? WIN_W'(1) : i_window;
          r_pair       <= '0;
          r_response   <= '0;
          r_tie        <= '0;
          r_err        <= 1'b0;
          r_sat        <= 1'b0;
          r_resp_valid <= 1'b0;
        end
        S_CLEAR: begin
          r_cnt_a   <= '0;
          r_cnt_b   <= '0;
          r_win_cnt <= r_win_len;
          r_idx_a   <= w_pair_bits[PAIR_W-1:SEL_W];
          r_idx_b   <= w_pair_bits[SEL_W-1:0];
        end
        S_COUNT: begin
          r_cnt_a   <= w_inc_a[CNT_W-1:0];
          r_cnt_b   <= w_inc_b[CNT_W-1:0];
          r_sat     <= r_sat | w_inc_a[CNT_W] | w_inc_b[CNT_W];
          r_win_cnt <= r_win_cnt - 1'b1;
        end
        S_COMPARE: begin
          r_response[r_pair] <= w_ok & (w_eff_a > w_eff_b);
          r_tie[r_pair]      <= w_ok & ((w_eff_a == w_eff_b) | (r_idx_a == r_idx_b));
          r_err              <= r_err | ~w_ok;
          r_last_a           <= w_eff_a;
          r_last_b           <= w_eff_b;
          if (w_last_pair) r_resp_valid <= 1'b1;
          else             r_pair       <= r_pair + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = w_busy;
  assign o_done       = w_done;
  assign o_response   = r_response;
  assign o_resp_valid = r_resp_valid;
  assign o_tie_mask   = r_tie;
  assign o_err        = r_err;
  assign o_sat        = r_sat;
  assign o_last_cnt_a = r_last_a;
  assign o_last_cnt_b = r_last_b;

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval: default instance plus a small-counter,
// six-oscillator instance for invalid-index and saturation cases.
module tb_ro_puf_eval;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [7:0]  ro = '0;
  logic [23:0] chal1 = '0, chal2 = '0;
  logic [15:0] win = '0;

  logic        busy1, done1, rv1, err1, sat1;
  logic [3:0]  resp1, tie1;
  logic [15:0] la1, lb1;
  logic        busy2, done2, rv2, err2, sat2;
  logic [3:0]  resp2, tie2;
  logic [3:0]  la2, lb2;

  int checks = 0;
  int errors = 0;
  int tick   = 0;

  ro_puf_eval dut1 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_ro_in(ro), .i_start(start1),
    .i_challenge(chal1), .i_window(win), .o_busy(busy1), .o_done(done1),
    .o_response(resp1), .o_resp_valid(rv1), .o_tie_mask(tie1), .o_err(err1),
    .o_sat(sat1), .o_last_cnt_a(la1), .o_last_cnt_b(lb1));

  ro_puf_eval #(.NUM_RO(6), .SEL_W(3), .RESP_BITS(4), .CNT_W(4), .WIN_W(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_ro_in(ro[5:0]), .i_start(start2),
    .i_challenge(chal2), .i_window(win), .o_busy(busy2), .o_done(done2),
    .o_response(resp2), .o_resp_valid(rv2), .o_tie_mask(tie2), .o_err(err2),
    .o_sat(sat2), .o_last_cnt_a(la2), .o_last_cnt_b(lb2));

  always #5 clk = ~clk;

  // ro[0]: period 4 clk, ro[1]: period 10 clk, others idle.
  always @(negedge clk) begin
    tick  = tick + 1;
    ro[0] = (tick % 4) < 2;
    ro[1] = (tick % 10) < 5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] pr(input logic [2:0] a, input logic [2:0] b);
    return {a, b};
  endfunction

  // Pulse start for one DUT and count clk edges until done (bounded).
  task automatic run(input int which, input int repulse, output int lat);
    @(negedge clk);
    if (which == 0) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
    lat = 0;
    while (lat < 5000) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if ((which == 0 && done1) || (which == 1 && done2)) break;
      if (repulse != 0 && lat == 5) start1 = 1'b1;
      if (repulse != 0 && lat == 6) start1 = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_rv", rv1, 0);
    chk("rst_resp", resp1, 0);
    rst_n = 1'b1;

    // Basic compare: all pairs {0,1}, window 100.
    chal1 = {pr(0,1), pr(0,1), pr(0,1), pr(0,1)};
    win   = 16'd100;
    run(0, 0, lat);
    chk("basic_lat", lat, 408);
    chk("basic_resp", resp1, 4'b1111);
    chk("basic_tie", tie1, 4'b0000);
    chk("basic_rv", rv1, 1);
    chk("basic_err", err1, 0);
    chk("basic_cnt_a_rng", 32'(la1 >= 16'd24 && la1 <= 16'd26), 1);
    chk("basic_cnt_b_rng", 32'(lb1 >= 16'd9 && lb1 <= 16'd11), 1);
    @(negedge clk);
    chk("done_pulse", done1, 0);
    chk("rv_hold", rv1, 1);

    // Async reset mid-COUNT with start held.
    start1 = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy1, 0);
    chk("arst_rv", rv1, 0);
    chk("arst_last_a", la1, 0);
    chk("arst_resp", resp1, 0);
    @(negedge clk);
    start1 = 1'b0;
    rst_n  = 1'b1;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy1) cnt++;
    end
    chk("idle_after_rst", cnt, 0);

    // Reversed and tie pairs.
    chal1 = {pr(3,3), pr(0,1), pr(2,2), pr(1,0)};
    run(0, 0, lat);
    chk("rev_lat", lat, 408);
    chk("rev_resp", resp1, 4'b0100);
    chk("rev_tie", tie1, 4'b1010);

    // Start re-pulsed while busy is ignored.
    chal1 = {pr(0,1), pr(0,1), pr(0,1), pr(0,1)};
    win   = 16'd10;
    run(0, 1, lat);
    chk("repulse_lat", lat, 48);
    chk("repulse_resp", resp1, 4'b1111);

    // Enable low in idle blocks acceptance.
    en = 1'b0;
    start1 = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy1) cnt++;
    end
    start1 = 1'b0;
    chk("en_block", cnt, 0);
    en = 1'b1;

    // Abort mid-COUNT.
    win = 16'd100;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_busy_pre", busy1, 1);
    en = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy1, 0);
    cnt = 0;
    repeat (450) begin
      @(negedge clk);
      if (done1) cnt++;
    end
    chk("abort_no_done", cnt, 0);
    chk("abort_rv", rv1, 0);
    en = 1'b1;

    // Window 0 behaves as 1.
    win = 16'd0;
    run(0, 0, lat);
    chk("win0_lat", lat, 12);
    chk("win0_rv", rv1, 1);

    // Invalid index and saturation on the small instance.
    chal2 = {pr(0,1), pr(0,1), pr(0,1), pr(7,0)};
    win   = 16'd200;
    run(1, 0, lat);
    chk("inv_lat", lat, 808);
    chk("inv_err", err2, 1);
    chk("inv_resp", resp2, 4'b0000);
    chk("inv_tie", tie2, 4'b1110);
    chk("sat_flag", sat2, 1);
    chk("sat_last_a", la2, 15);
    chk("sat_last_b", lb2, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ro_puf_eval.md
Name: ro_puf_eval

Overview:
Parametrised ring-oscillator PUF evaluation controller. It takes NUM_RO pre-divided oscillator signals and a packed challenge of RESP_BITS oscillator-pair selections. For each pair it counts oscillator edges over a programmable clk-cycle window, then compares the two counts to produce one response bit. It replaces the fixed two-counter/one-comparator arrangement with a sequenced, handshaked, multi-bit evaluator that sits between the oscillator banks and the top-level I/O.

Parameters:
NUM_RO, 8, number of oscillator inputs (2..32)
SEL_W, 3, index width per oscillator select; 2^SEL_W >= NUM_RO
RESP_BITS, 4, response bits (pair comparisons) per request
CNT_W, 16, edge-counter width, saturating
WIN_W, 16, window-length field width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  block enable; low aborts any evaluation
ro_in  in  NUM_RO  oscillator outputs, asynchronous; each guaranteed below clk/4
start  in  1  request pulse/level; sampled only in IDLE
challenge  in  RESP_BITS*2*SEL_W  pair i = {idx_a, idx_b} at bits [2*SEL_W*i +: 2*SEL_W], idx_a in the upper SEL_W bits
window  in  WIN_W  count window in clk cycles; 0 is treated as 1
busy  out  1  high from the cycle after start acceptance until done
done  out  1  one-cycle pulse at end of request
response  out  RESP_BITS  bit i = (count_a > count_b) for pair i
resp_valid  out  1  response holds a completed result
tie_mask  out  RESP_BITS  bit i set when count_a == count_b or idx_a == idx_b
err  out  1  any pair index >= NUM_RO in the last request
sat  out  1  any counter saturated in the last request
last_cnt_a  out  CNT_W  count_a of the most recently compared pair
last_cnt_b  out  CNT_W  count_b of the most recently compared pair

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizers and counters cleared.
- Each ro_in bit passes a 2-FF synchronizer plus an edge-detect register. A rising edge is synced(t)=1 and synced(t-1)=0.
- FSM states: IDLE, CLEAR, COUNT, COMPARE, DONE.
- IDLE: when en=1 and start=1, latch challenge and window (0 becomes 1), clear the pair index, clear response, tie_mask, err and sat, drop resp_valid, and go to CLEAR. In all other states start is ignored.
- CLEAR (1 cycle): clear count_a and count_b, load the window down-counter, decode idx_a/idx_b for the current pair, then go to COUNT.
- COUNT (exactly W cycles): each counter increments on a rising edge of its selected synced input. Counters saturate at 2^CNT_W-1 and set sat. When the window counter reaches its last cycle, go to COMPARE.
- COMPARE (1 cycle):
  - response[i] = count_a > count_b.
  - tie_mask[i] = equal counts or idx_a == idx_b.
  - If either index >= NUM_RO: response[i]=0, tie_mask[i]=0, err=1, and that counter reads 0.
  - Update last_cnt_a/last_cnt_b.
  - If i < RESP_BITS-1: increment i and go to CLEAR. Otherwise go to DONE.
- DONE (1 cycle): done=1, resp_valid=1, busy=0 in this cycle, then go to IDLE.
- Latency: done is high exactly RESP_BITS*(W+2) cycles after the clk edge at which start was sampled.
- busy is 1 in CLEAR, COUNT and COMPARE.
- en=0 in any non-IDLE state: go to IDLE next cycle with no done pulse. resp_valid stays 0; response and tie_mask keep partial values but are not valid.
- en=0 in IDLE blocks start acceptance.
- Asynchronous rst_n mid-operation: immediate return to reset values.
- Outputs response, tie_mask, err, sat and last_cnt_* hold their values until the next accepted start.
- Edges arriving during CLEAR or COMPARE are not counted.

Test Plan:
- Reset then idle: assert rst_n low mid-COUNT with start held → all outputs 0 immediately. After release with start=0, busy stays 0 for 50 cycles.
- Basic compare: NUM_RO=8, window=100.
  - Stimulus: ro_in[0] period 4 clk, ro_in[1] period 10 clk; challenge all pairs {0,1}.
  - Required: done exactly 408 cycles after start; response=4'b1111; last_cnt_a in 24..26; last_cnt_b in 9..11; tie_mask=0.
- Reversed/tie pairs: pairs {1,0},{2,2},{0,1},{3,3} with ro_in[2], ro_in[3] idle → response=4'b0100, tie_mask=4'b1010.
- Invalid index and saturation (NUM_RO=6, CNT_W=4):
  - Pair {7,0}: err=1, response[0]=0.
  - Pair {0,1} with window=200: sat=1, last_cnt_a=15.
- Abort/ignore: start pulsed again while busy → no restart, done timing unchanged. Drop en mid-COUNT → no done, resp_valid=0, busy=0 within 1 cycle.
- window=0 → behaves as window=1; done at RESP_BITS*3 cycles after start.
